// File: rtl/regfile_sb.sv
// regfile_sb: register file with a per-register busy scoreboard for the
// operand-read stage.
//
// It has one write port, two combinational read ports with optional
// write-to-read bypass, and an optional hardwired zero register. A claim marks
// a register busy for a multicycle producer. The producer's write-back clears
// the busy bit again.
//
// Ports:
//   clock             rising-edge clock
//   ctrl_reset        synchronous active-high reset (clears data, busy, count)
//   ctrl_writeEnable  write strobe; ctrl_writeReg / data_writeReg address/data
//   ctrl_claimEnable  claim strobe; ctrl_claimReg register to mark busy
//   ctrl_readRegA/B   read addresses
//   data_readRegA/B   read data (combinational, optionally bypassed)
//   busy_readRegA/B   busy bit of the addressed register
//   busy_count        registered number of busy registers
module regfile_sb #(
   parameter int WIDTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clock,
   input  logic              ctrl_reset,
   input  logic              ctrl_writeEnable,
   input  logic [ADDR_W-1:0] ctrl_writeReg,
   input  logic [WIDTH-1:0]  data_writeReg,
   input  logic              ctrl_claimEnable,
   input  logic [ADDR_W-1:0] ctrl_claimReg,
   input  logic [ADDR_W-1:0] ctrl_readRegA,
   input  logic [ADDR_W-1:0] ctrl_readRegB,
   output logic [WIDTH-1:0]  data_readRegA,
   output logic [WIDTH-1:0]  data_readRegB,
   output logic              busy_readRegA,
   output logic              busy_readRegB,
   output logic [ADDR_W:0]   busy_count
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0] busy_q, busy_d;
   logic [ADDR_W:0]  busy_count_q, busy_count_d;

   logic wr_ok, cl_ok, cnt_inc, cnt_dec;

   // Strobes that address the hardwired zero register have no effect.
   always_comb begin
      wr_ok = ctrl_writeEnable && !((ZERO_REG != 0) && (ctrl_writeReg == '0));
      cl_ok = ctrl_claimEnable && !((ZERO_REG != 0) && (ctrl_claimReg == '0));
   end

   // Next state. The claim is applied after the write, so that a claim and a
   // write to the same register leave it busy: the new producer wins.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (wr_ok) begin
         regs_d[ctrl_writeReg] = data_writeReg;
         busy_d[ctrl_writeReg] = 1'b0;
      end
      if (cl_ok) begin
         busy_d[ctrl_claimReg] = 1'b1;
      end
   end

   // The count is updated incrementally from the strobes and is not recounted
   // from the busy bits. A claim adds one only if its register was idle. A
   // write removes one only if its register was busy and is not claimed again
   // in the same cycle.
   always_comb begin
      cnt_inc      = cl_ok && !busy_q[ctrl_claimReg];
      cnt_dec      = wr_ok && busy_q[ctrl_writeReg]
                     && !(cl_ok && (ctrl_claimReg == ctrl_writeReg));
      busy_count_d = busy_count_q + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
   end

   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         busy_q       <= '0;
         busy_count_q <= '0;
      end else begin
         regs_q       <= regs_d;
         busy_q       <= busy_d;
         busy_count_q <= busy_count_d;
      end
   end

   // Read ports
   logic [ADDR_W-1:0] rd_addr [2];
   logic [WIDTH-1:0]  rd_data [2];
   logic              rd_busy [2];

   assign rd_addr[0] = ctrl_readRegA;
   assign rd_addr[1] = ctrl_readRegB;

   // A bypassed read shows the state after the edge. Its busy bit is set only
   // when the same register is also claimed in this cycle.
   always_comb begin
      for (int unsigned p = 0; p < 2; p++) begin
         rd_data[p] = regs_q[rd_addr[p]];
         rd_busy[p] = busy_q[rd_addr[p]];
         if ((BYPASS != 0) && ctrl_writeEnable && !ctrl_reset
             && (ctrl_writeReg == rd_addr[p])) begin
            rd_data[p] = data_writeReg;
            rd_busy[p] = ctrl_claimEnable && (ctrl_claimReg == ctrl_writeReg);
         end
         if ((ZERO_REG != 0) && (rd_addr[p] == '0)) begin
            rd_data[p] = '0;
            rd_busy[p] = 1'b0;
         end
      end
   end

   assign data_readRegA = rd_data[0];
   assign data_readRegB = rd_data[1];
   assign busy_readRegA = rd_busy[0];
   assign busy_readRegB = rd_busy[1];
   assign busy_count    = busy_count_q;

endmodule
